// File: rtl/vend_pkg.sv
// Shared types, default price table and price lookup helper for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } vend_state_e;

  localparam int DEF_NUM_PROD = 4;
  localparam int DEF_CREDIT_W = 6;
  localparam logic [DEF_NUM_PROD*DEF_CREDIT_W-1:0] DEF_PRICES = {6'd9, 6'd8, 6'd6, 6'd5};

  // Widest table the helper handles: 16 products of up to 32 bits each.
  localparam int PRICE_TBL_W = 512;

  function automatic logic [31:0] price_of(input logic [PRICE_TBL_W-1:0] tbl,
                                           input int width, input int id);
    logic [31:0] p;
    logic [8:0]  idx;
    p = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < width && (id * width + b) < PRICE_TBL_W) begin
        idx  = 9'(id * width + b);
        p[b] = tbl[idx];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/vend_price_lut.sv
// Combinational price lookup; valid drops for product ids beyond the table.
module vend_price_lut
  import vend_pkg::*;
#(
  parameter int NUM_PROD = DEF_NUM_PROD,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = DEF_PRICES
) (
  input  logic [$clog2(NUM_PROD)-1:0] sel_id,
  output logic [CREDIT_W-1:0]         price,
  output logic                        valid
);

  always_comb begin
    price = CREDIT_W'(price_of(PRICE_TBL_W'(PRICES), CREDIT_W, int'(sel_id)));
    valid = (int'(sel_id) < NUM_PROD);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending FSM: collects coin credit, vends via ready/valid and
// refunds residual credit as change pulses, reusing the credit register as counter.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_PROD   = DEF_NUM_PROD,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter int MAX_CREDIT = 31,
  parameter bit MULTI_VEND = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_valid,
  input  logic [CREDIT_W-1:0]         coin_value,
  input  logic                        sel_valid,
  input  logic [$clog2(NUM_PROD)-1:0] sel_id,
  input  logic                        cancel,
  input  logic                        vend_ready,
  output logic                        vend_valid,
  output logic [$clog2(NUM_PROD)-1:0] vend_id,
  output logic                        change_pulse,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        coin_reject,
  output logic                        err_sel
);

  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_VEND    = VEND;
  localparam logic [1:0] ST_CHANGE  = CHANGE;
  localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE     = CREDIT_W'(1);

  logic [1:0]                  state_reg, state_next;
  logic [CREDIT_W-1:0]         credit_reg, credit_next;
  logic [$clog2(NUM_PROD)-1:0] vend_id_reg, vend_id_next;
  logic                        vend_valid_reg, vend_valid_next;
  logic                        change_pulse_reg, change_pulse_next;
  logic                        coin_reject_reg, coin_reject_next;
  logic                        err_sel_reg, err_sel_next;

  logic [CREDIT_W-1:0] lut_price;
  logic                lut_valid;
  logic [CREDIT_W:0]   coin_sum;

  vend_price_lut #(
    .NUM_PROD(NUM_PROD),
    .CREDIT_W(CREDIT_W),
    .PRICES  (PRICES)
  ) u_price_lut (
    .sel_id(sel_id),
    .price (lut_price),
    .valid (lut_valid)
  );

  // One extra bit so an overflowing coin is detected rather than wrapped.
  assign coin_sum = {1'b0, credit_reg} + {1'b0, coin_value};

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    vend_id_next     = vend_id_reg;
    coin_reject_next = 1'b0;
    err_sel_next     = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        if (cancel && credit_reg != '0) begin
          state_next       = ST_CHANGE;
          coin_reject_next = coin_valid;
        end else if (sel_valid) begin
          coin_reject_next = coin_valid;
          if (lut_valid && credit_reg >= lut_price) begin
            credit_next  = credit_reg - lut_price;
            vend_id_next = sel_id;
            state_next   = ST_VEND;
          end else begin
            err_sel_next = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_sum <= MAX_SUM) credit_next = coin_sum[CREDIT_W-1:0];
          else                     coin_reject_next = 1'b1;
        end
      end
      ST_VEND: begin
        coin_reject_next = coin_valid;
        if (vend_ready)
          state_next = (credit_reg == '0 || MULTI_VEND) ? ST_COLLECT : ST_CHANGE;
      end
      ST_CHANGE: begin
        coin_reject_next = coin_valid;
        if (credit_reg != '0) credit_next = credit_reg - ONE;
        if (credit_reg <= ONE) state_next = ST_COLLECT;
      end
      default: state_next = ST_COLLECT;
    endcase
    vend_valid_next   = (state_next == ST_VEND);
    change_pulse_next = (state_next == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_COLLECT;
      credit_reg       <= '0;
      vend_id_reg      <= '0;
      vend_valid_reg   <= 1'b0;
      change_pulse_reg <= 1'b0;
      coin_reject_reg  <= 1'b0;
      err_sel_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      vend_id_reg      <= vend_id_next;
      vend_valid_reg   <= vend_valid_next;
      change_pulse_reg <= change_pulse_next;
      coin_reject_reg  <= coin_reject_next;
      err_sel_reg      <= err_sel_next;
    end
  end

  assign vend_valid   = vend_valid_reg;
  assign vend_id      = vend_id_reg;
  assign change_pulse = change_pulse_reg;
  assign credit       = credit_reg;
  assign coin_reject  = coin_reject_reg;
  assign err_sel      = err_sel_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: refund-mode instance plus a MULTI_VEND=1 instance on shared stimulus.
module tb_vend_ctrl;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       vend_ready;

  logic       vend_valid, change_pulse, coin_reject, err_sel;
  logic [1:0] vend_id;
  logic [5:0] credit;
  logic       m_vend_valid, m_change_pulse, m_coin_reject, m_err_sel;
  logic [1:0] m_vend_id;
  logic [5:0] m_credit;

  int n_cmp = 0;
  int n_bad = 0;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .vend_ready(vend_ready),
    .vend_valid(vend_valid), .vend_id(vend_id), .change_pulse(change_pulse),
    .credit(credit), .coin_reject(coin_reject), .err_sel(err_sel)
  );

  vend_ctrl #(.MULTI_VEND(1'b1)) dut_m (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .vend_ready(vend_ready),
    .vend_valid(m_vend_valid), .vend_id(m_vend_id), .change_pulse(m_change_pulse),
    .credit(m_credit), .coin_reject(m_coin_reject), .err_sel(m_err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic put_coin(input logic [5:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (credit !== 6'd0) begin n_bad++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    n_cmp++; if ({vend_valid, vend_id, change_pulse, coin_reject, err_sel} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected 000000", {vend_valid, vend_id, change_pulse, coin_reject, err_sel}); end
    rst = 1'b0;
    tick();
    $display("txn reset: credit=%0d vend_valid=%0b", credit, vend_valid);
  endtask

  task automatic test_basic_vend();
    int pulses;
    do_reset();
    put_coin(6'd2);
    put_coin(6'd2);
    put_coin(6'd2);
    n_cmp++; if (credit !== 6'd6) begin n_bad++; $display("FAIL basic_credit: got %0d expected 6", credit); end
    vend_ready = 1'b1;
    select(2'd0);
    n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd0) begin
      n_bad++; $display("FAIL basic_vend: got valid=%0b id=%0d expected valid=1 id=0", vend_valid, vend_id); end
    n_cmp++; if (credit !== 6'd1) begin n_bad++; $display("FAIL basic_credit_after_sel: got %0d expected 1", credit); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++; if (vend_valid !== 1'b0) begin n_bad++; $display("FAIL basic_vend_drop: got %0b expected 0", vend_valid); end
      end
      if (change_pulse === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (credit !== 6'd0) begin n_bad++; $display("FAIL basic_credit_end: got %0d expected 0", credit); end
    vend_ready = 1'b0;
    $display("txn basic_vend: pulses=%0d credit=%0d", pulses, credit);
  endtask

  task automatic test_err_sel();
    do_reset();
    put_coin(6'd4);
    select(2'd1);
    n_cmp++; if (err_sel !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %0b expected 1", err_sel); end
    n_cmp++; if (credit !== 6'd4 || vend_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_state: got credit=%0d valid=%0b expected credit=4 valid=0", credit, vend_valid); end
    tick();
    n_cmp++; if (err_sel !== 1'b0) begin n_bad++; $display("FAIL err_width: got %0b expected 0", err_sel); end
    $display("txn err_sel: credit=%0d", credit);
  endtask

  task automatic test_overflow();
    do_reset();
    put_coin(6'd30);
    put_coin(6'd3);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 6'd30) begin
      n_bad++; $display("FAIL ovf_reject: got rej=%0b credit=%0d expected rej=1 credit=30", coin_reject, credit); end
    tick();
    n_cmp++; if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL ovf_reject_width: got %0b expected 0", coin_reject); end
    put_coin(6'd1);
    n_cmp++; if (coin_reject !== 1'b0 || credit !== 6'd31) begin
      n_bad++; $display("FAIL ovf_max: got rej=%0b credit=%0d expected rej=0 credit=31", coin_reject, credit); end
    put_coin(6'd0);
    n_cmp++; if (coin_reject !== 1'b0 || credit !== 6'd31) begin
      n_bad++; $display("FAIL ovf_zero_coin: got rej=%0b credit=%0d expected rej=0 credit=31", coin_reject, credit); end
    $display("txn overflow: credit=%0d", credit);
  endtask

  task automatic test_stall();
    int pulses;
    do_reset();
    put_coin(6'd10);
    vend_ready = 1'b0;
    select(2'd2);
    n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd2 || credit !== 6'd2) begin
      n_bad++; $display("FAIL stall_start: got valid=%0b id=%0d credit=%0d expected 1/2/2", vend_valid, vend_id, credit); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin coin_valid = 1'b1; coin_value = 6'd1; end
      tick();
      coin_valid = 1'b0;
      n_cmp++; if (vend_valid !== 1'b1 || vend_id !== 2'd2) begin
        n_bad++; $display("FAIL stall_hold%0d: got valid=%0b id=%0d expected 1/2", i, vend_valid, vend_id); end
      if (i == 1) begin
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 6'd2) begin
          n_bad++; $display("FAIL stall_coin: got rej=%0b credit=%0d expected rej=1 credit=2", coin_reject, credit); end
      end
    end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_cmp++; if (vend_valid !== 1'b0 || change_pulse !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: got valid=%0b pulse=%0b expected 0/1", vend_valid, change_pulse); end
    pulses = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (change_pulse === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 2 || credit !== 6'd0) begin
      n_bad++; $display("FAIL stall_change: got pulses=%0d credit=%0d expected 2/0", pulses, credit); end
    $display("txn stall: pulses=%0d", pulses);
  endtask

  task automatic test_multi_vend();
    int pulses;
    do_reset();
    put_coin(6'd20);
    vend_ready = 1'b1;
    select(2'd3);
    n_cmp++; if (m_vend_valid !== 1'b1 || m_vend_id !== 2'd3 || m_credit !== 6'd11) begin
      n_bad++; $display("FAIL multi_sel3: got valid=%0b id=%0d credit=%0d expected 1/3/11", m_vend_valid, m_vend_id, m_credit); end
    tick();
    n_cmp++; if (m_vend_valid !== 1'b0 || m_change_pulse !== 1'b0 || m_credit !== 6'd11) begin
      n_bad++; $display("FAIL multi_keep: got valid=%0b pulse=%0b credit=%0d expected 0/0/11", m_vend_valid, m_change_pulse, m_credit); end
    select(2'd0);
    n_cmp++; if (m_vend_valid !== 1'b1 || m_vend_id !== 2'd0 || m_credit !== 6'd6) begin
      n_bad++; $display("FAIL multi_sel0: got valid=%0b id=%0d credit=%0d expected 1/0/6", m_vend_valid, m_vend_id, m_credit); end
    tick();
    vend_ready = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_change_pulse === 1'b1 && m_credit === 6'(6 - i)) pulses++;
      tick();
    end
    n_cmp++; if (pulses != 6) begin n_bad++; $display("FAIL multi_cancel_pulses: got %0d expected 6", pulses); end
    n_cmp++; if (m_change_pulse !== 1'b0 || m_credit !== 6'd0) begin
      n_bad++; $display("FAIL multi_cancel_end: got pulse=%0b credit=%0d expected 0/0", m_change_pulse, m_credit); end
    $display("txn multi_vend: pulses=%0d credit=%0d", pulses, m_credit);
  endtask

  task automatic test_cancel_reset();
    int pulses;
    do_reset();
    put_coin(6'd7);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_value = 6'd1;
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    n_cmp++; if (coin_reject !== 1'b1 || change_pulse !== 1'b1 || credit !== 6'd7) begin
      n_bad++; $display("FAIL cancel_coin: got rej=%0b pulse=%0b credit=%0d expected 1/1/7", coin_reject, change_pulse, credit); end
    tick();
    tick();
    n_cmp++; if (change_pulse !== 1'b1 || credit !== 6'd5) begin
      n_bad++; $display("FAIL cancel_pulse3: got pulse=%0b credit=%0d expected 1/5", change_pulse, credit); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({vend_valid, vend_id, change_pulse, coin_reject, err_sel} !== 6'b0 || credit !== 6'd0) begin
      n_bad++; $display("FAIL async_reset: got outs=%b credit=%0d expected 000000/0",
                        {vend_valid, vend_id, change_pulse, coin_reject, err_sel}, credit); end
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (change_pulse === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL post_reset_pulses: got %0d expected 0", pulses); end
    $display("txn cancel_reset: post-reset pulses=%0d", pulses);
  endtask

  initial begin
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin_value = '0;
    sel_valid  = 1'b0;
    sel_id     = '0;
    cancel     = 1'b0;
    vend_ready = 1'b0;
    test_reset();
    test_basic_vend();
    test_err_sel();
    test_overflow();
    test_stall();
    test_multi_vend();
    test_cancel_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
